// File: rtl/ring_send_ctrl.sv
// Circular FIFO of 32-bit word pairs feeding a single downstream buffer register.
// Exactly one pair is in flight at a time; the next pop waits for buf_ack.
module ring_send_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   push,
    input  logic [31:0]            push_a,
    input  logic [31:0]            push_b,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count,
    output logic                   buf_write,
    output logic [31:0]            buf_in_1,
    output logic [31:0]            buf_in_2,
    input  logic                   buf_ack,
    output logic                   busy,
    output logic                   drop_err,
    output logic [1:0]             state_dbg
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] SEND     = 2'd1;
    localparam logic [1:0] WAIT_ACK = 2'd2;

    logic [63:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [1:0]    state;
    logic          push_ok;
    logic          pop;

    // Downstream handshake: buf_write pulses for one cycle when buf_in_1/2 are
    // loaded; the consumer owns that pair until buf_ack is seen in WAIT_ACK.
    // An ack in IDLE or SEND is ignored and not remembered.
    assign full      = (count == CW'(DEPTH));
    assign push_ok   = push && !full;
    assign pop       = (state == IDLE) && (count != '0);
    assign busy      = (state == SEND) || (state == WAIT_ACK);
    assign state_dbg = state;

    // Storage is deliberately left out of reset; only pointers and count matter.
    always_ff @(posedge Clk) begin
        if (!Reset && push_ok) begin
            mem[wr_ptr] <= {push_a, push_b};
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            buf_write <= 1'b0;
            buf_in_1  <= '0;
            buf_in_2  <= '0;
            drop_err  <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push_ok && !pop) begin
                count <= count + CW'(1);
            end else if (!push_ok && pop) begin
                count <= count - CW'(1);
            end
            if (push && full) begin
                drop_err <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (pop) begin
                        {buf_in_1, buf_in_2} <= mem[rd_ptr];
                        buf_write            <= 1'b1;
                        state                <= SEND;
                    end
                end
                SEND: begin
                    buf_write <= 1'b0;
                    state     <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (buf_ack) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    buf_write <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ring_send_ctrl.sv
// Directed bench for ring_send_ctrl: cycle-by-cycle vector table plus streamed
// order/backpressure and wrap-around sequences checked against an expected queue.
module tb_ring_send_ctrl;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          push = 1'b0;
    logic [31:0]   push_a = '0;
    logic [31:0]   push_b = '0;
    logic          buf_ack = 1'b0;
    logic          full;
    logic [CW-1:0] count;
    logic          buf_write;
    logic [31:0]   buf_in_1;
    logic [31:0]   buf_in_2;
    logic          busy;
    logic          drop_err;
    logic [1:0]    state_dbg;

    int errors = 0;
    int checks = 0;
    logic [63:0] exp_q[$];

    ring_send_ctrl #(.DEPTH(DEPTH)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .push      (push),
        .push_a    (push_a),
        .push_b    (push_b),
        .full      (full),
        .count     (count),
        .buf_write (buf_write),
        .buf_in_1  (buf_in_1),
        .buf_in_2  (buf_in_2),
        .buf_ack   (buf_ack),
        .busy      (busy),
        .drop_err  (drop_err),
        .state_dbg (state_dbg)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic          rst;
        logic          psh;
        logic [31:0]   a;
        logic [31:0]   b;
        logic          ack;
        logic          e_full;
        logic [CW-1:0] e_count;
        logic          e_bw;
        logic [31:0]   e_in1;
        logic [31:0]   e_in2;
        logic          e_busy;
        logic          e_drop;
    } vec_t;

    localparam int NV = 29;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic setv(input int i, input logic rst, input logic psh, input logic [31:0] a,
                        input logic [31:0] b, input logic ack, input logic e_full,
                        input logic [CW-1:0] e_count, input logic e_bw, input logic [31:0] e_in1,
                        input logic [31:0] e_in2, input logic e_busy, input logic e_drop);
        vecs[i] = '{rst, psh, a, b, ack, e_full, e_count, e_bw, e_in1, e_in2, e_busy, e_drop};
    endtask

    // Streams n pairs through the DUT; burst pushes on consecutive cycles, otherwise
    // each pair is pushed only after the previous one has been acked.
    task automatic run_stream(input string tag, input int n, input bit burst,
                              input int ack_delay, input int exp_peak);
        int pushed = 0;
        int delivered = 0;
        int ack_cnt = 0;
        int peak = 0;
        int cyc = 0;
        bit outstanding = 0;
        logic [31:0] a;
        logic [63:0] exp;
        exp_q.delete();
        while ((delivered < n || outstanding) && cyc < 400) begin
            push    = 1'b0;
            buf_ack = 1'b0;
            if (outstanding) begin
                ack_cnt--;
                if (ack_cnt == 0) begin
                    buf_ack     = 1'b1;
                    outstanding = 0;
                end
            end
            if (pushed < n && (burst || (!outstanding && !busy && count == '0 && delivered == pushed))) begin
                a      = 32'hC000_0000 | 32'(pushed) | (32'(n) << 16);
                push   = 1'b1;
                push_a = a;
                push_b = ~a;
                exp_q.push_back({a, ~a});
                pushed++;
            end
            step();
            cyc++;
            if (int'(count) > peak) peak = int'(count);
            if (buf_write) begin
                if (outstanding || exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL %s_extra_write: got buf_write=1 expected 0 (pair outstanding or none queued)", tag);
                end else begin
                    exp = exp_q.pop_front();
                    check({tag, "_in1"}, buf_in_1, exp[63:32]);
                    check({tag, "_in2"}, buf_in_2, exp[31:0]);
                end
                outstanding = 1;
                ack_cnt     = ack_delay;
                delivered++;
            end else if (outstanding) begin
                check({tag, "_busy_hold"}, 32'(busy), 32'd1);
            end
        end
        push    = 1'b0;
        buf_ack = 1'b0;
        check({tag, "_timeout"}, 32'(cyc < 400), 32'd1);
        check({tag, "_delivered"}, 32'(delivered), 32'(n));
        check({tag, "_queue_left"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_count_end"}, 32'(count), 32'd0);
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
        check({tag, "_peak"}, 32'(peak), 32'(exp_peak));
    endtask

    initial begin
        // rst psh a b ack | full count bw in1 in2 busy drop
        setv(0,  1, 0, 0, 0, 0,                       0, 0, 0, 0, 0, 0, 0);
        setv(1,  0, 1, 32'h1111_1111, 32'h2222_2222, 0, 0, 1, 0, 0, 0, 0, 0);
        setv(2,  0, 0, 0, 0, 0,                       0, 0, 1, 32'h1111_1111, 32'h2222_2222, 1, 0);
        setv(3,  0, 0, 0, 0, 1,                       0, 0, 0, 32'h1111_1111, 32'h2222_2222, 1, 0);
        setv(4,  0, 0, 0, 0, 0,                       0, 0, 0, 32'h1111_1111, 32'h2222_2222, 1, 0);
        setv(5,  0, 0, 0, 0, 1,                       0, 0, 0, 32'h1111_1111, 32'h2222_2222, 0, 0);
        setv(6,  0, 0, 0, 0, 0,                       0, 0, 0, 32'h1111_1111, 32'h2222_2222, 0, 0);
        setv(7,  0, 0, 0, 0, 1,                       0, 0, 0, 32'h1111_1111, 32'h2222_2222, 0, 0);
        setv(8,  0, 1, 32'h0000_00A3, 32'h0000_00B3, 0, 0, 1, 0, 32'h1111_1111, 32'h2222_2222, 0, 0);
        setv(9,  0, 0, 0, 0, 0,                       0, 0, 1, 32'h0000_00A3, 32'h0000_00B3, 1, 0);
        setv(10, 0, 0, 0, 0, 0,                       0, 0, 0, 32'h0000_00A3, 32'h0000_00B3, 1, 0);
        setv(11, 0, 0, 0, 0, 0,                       0, 0, 0, 32'h0000_00A3, 32'h0000_00B3, 1, 0);
        setv(12, 0, 0, 0, 0, 1,                       0, 0, 0, 32'h0000_00A3, 32'h0000_00B3, 0, 0);
        setv(13, 0, 1, 32'h1000_0001, 32'h2000_0001, 0, 0, 1, 0, 32'h0000_00A3, 32'h0000_00B3, 0, 0);
        setv(14, 0, 1, 32'h1000_0002, 32'h2000_0002, 0, 0, 1, 1, 32'h1000_0001, 32'h2000_0001, 1, 0);
        setv(15, 0, 1, 32'h1000_0003, 32'h2000_0003, 0, 0, 2, 0, 32'h1000_0001, 32'h2000_0001, 1, 0);
        setv(16, 0, 1, 32'h1000_0004, 32'h2000_0004, 0, 0, 3, 0, 32'h1000_0001, 32'h2000_0001, 1, 0);
        setv(17, 0, 1, 32'h1000_0005, 32'h2000_0005, 0, 1, 4, 0, 32'h1000_0001, 32'h2000_0001, 1, 0);
        setv(18, 0, 1, 32'h1000_0006, 32'h2000_0006, 0, 1, 4, 0, 32'h1000_0001, 32'h2000_0001, 1, 1);
        setv(19, 0, 1, 32'h1000_0007, 32'h2000_0007, 0, 1, 4, 0, 32'h1000_0001, 32'h2000_0001, 1, 1);
        setv(20, 0, 0, 0, 0, 1,                       1, 4, 0, 32'h1000_0001, 32'h2000_0001, 0, 1);
        setv(21, 0, 1, 32'h1000_0008, 32'h2000_0008, 0, 0, 3, 1, 32'h1000_0002, 32'h2000_0002, 1, 1);
        setv(22, 0, 0, 0, 0, 0,                       0, 3, 0, 32'h1000_0002, 32'h2000_0002, 1, 1);
        setv(23, 0, 0, 0, 0, 1,                       0, 3, 0, 32'h1000_0002, 32'h2000_0002, 0, 1);
        setv(24, 0, 0, 0, 0, 0,                       0, 2, 1, 32'h1000_0003, 32'h2000_0003, 1, 1);
        setv(25, 0, 0, 0, 0, 0,                       0, 2, 0, 32'h1000_0003, 32'h2000_0003, 1, 1);
        setv(26, 1, 1, 32'h1000_0009, 32'h2000_0009, 1, 0, 0, 0, 0, 0, 0, 0);
        setv(27, 0, 0, 0, 0, 0,                       0, 0, 0, 0, 0, 0, 0);
        setv(28, 0, 0, 0, 0, 0,                       0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < NV; i++) begin
            Reset   = vecs[i].rst;
            push    = vecs[i].psh;
            push_a  = vecs[i].a;
            push_b  = vecs[i].b;
            buf_ack = vecs[i].ack;
            step();
            check($sformatf("v%0d_full", i), 32'(full), 32'(vecs[i].e_full));
            check($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].e_count));
            check($sformatf("v%0d_buf_write", i), 32'(buf_write), 32'(vecs[i].e_bw));
            check($sformatf("v%0d_buf_in_1", i), buf_in_1, vecs[i].e_in1);
            check($sformatf("v%0d_buf_in_2", i), buf_in_2, vecs[i].e_in2);
            check($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
            check($sformatf("v%0d_drop_err", i), 32'(drop_err), 32'(vecs[i].e_drop));
            if (vecs[i].rst) begin
                check($sformatf("v%0d_state_idle", i), 32'(state_dbg), 32'd0);
            end
        end
        Reset   = 1'b0;
        push    = 1'b0;
        buf_ack = 1'b0;

        run_stream("order", 4, 1'b1, 5, 3);
        run_stream("wrap", 10, 1'b0, 2, 1);
        check("final_drop_err", 32'(drop_err), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
